regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 85 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard for an in-order issue stage.
// Reads are combinational with optional same-cycle writeback forwarding.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  input  logic            RS1_USED,
  input  logic            RS2_USED,
  output logic [XLEN-1:0] DATA1,
  output logic [XLEN-1:0] DATA2,
  input  logic            WRITEENABLE,
  input  logic [AW-1:0]   WRITEADDRESS,
  input  logic [XLEN-1:0] WRITEDATA,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_RD,
  output logic            BUSY1,
  output logic            BUSY2,
  output logic            STALL,
  output logic            ISSUE_ACCEPT,
  output logic [AW:0]     PENDING_CNT
);

  logic [XLEN-1:0] regFile [DEPTH];
  logic [DEPTH-1:0] busyBits;
  logic [DEPTH-1:0] busyNext;

  logic wbValid;
  logic fwd1;
  logic fwd2;
  logic zero1;
  logic zero2;
  logic issueSet;
  logic cntInc;
  logic cntDec;

  // A writeback to the hardwired zero register is dropped entirely.
  assign wbValid = WRITEENABLE && !((ZERO_REG != 0) && (WRITEADDRESS == '0));

  assign zero1 = (ZERO_REG != 0) && (RS1 == '0);
  assign zero2 = (ZERO_REG != 0) && (RS2 == '0);
  assign fwd1  = (BYPASS != 0) && wbValid && (WRITEADDRESS == RS1);
  assign fwd2  = (BYPASS != 0) && wbValid && (WRITEADDRESS == RS2);

  assign DATA1 = fwd1 ? WRITEDATA : (zero1 ? '0 : regFile[RS1]);
  assign DATA2 = fwd2 ? WRITEDATA : (zero2 ? '0 : regFile[RS2]);
  assign BUSY1 = busyBits[RS1] && !fwd1;
  assign BUSY2 = busyBits[RS2] && !fwd2;

  assign STALL        = (BUSY1 && RS1_USED) || (BUSY2 && RS2_USED);
  assign ISSUE_ACCEPT = ISSUE_EN && !STALL;
  assign issueSet     = ISSUE_ACCEPT && !((ZERO_REG != 0) && (ISSUE_RD == '0));

  // The count only moves when a busy bit actually flips; a set on the
  // register being written back keeps it busy, so neither side counts.
  assign cntInc = issueSet && !busyBits[ISSUE_RD];
  assign cntDec = wbValid && busyBits[WRITEADDRESS]
                  && !(issueSet && (ISSUE_RD == WRITEADDRESS));

  always_comb begin
    busyNext = busyBits;
    if (wbValid) busyNext[WRITEADDRESS] = 1'b0;
    if (issueSet) busyNext[ISSUE_RD] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
      busyBits    <= '0;
      PENDING_CNT <= '0;
    end else begin
      if (wbValid) regFile[WRITEADDRESS] <= WRITEDATA;
      busyBits <= busyNext;
      if (cntInc && !cntDec) PENDING_CNT <= PENDING_CNT + 1'b1;
      else if (cntDec && !cntInc) PENDING_CNT <= PENDING_CNT - 1'b1;
    end
  end

endmodule
